mesh_layer_barrier: RTL and testbench
=====================================

Name: mesh_layer_barrier

Overview:
- Mesh-level layer sequencer for a rectangular MESH_X x MESH_Y NoC of PEs.
- Broadcasts a per-layer start pulse to all nodes and collects per-node done signals into a masked barrier.
- Advances through a programmable number of layers, reports completion, and flags a watchdog timeout.
- Replaces the single-level AND-of-done aggregation with multi-layer, masked, edge-qualified, timed operation.

Parameters:
MESH_X, 4, mesh columns (>=1)
MESH_Y, 4, mesh rows (>=1)
LAYER_W, 8, width of layer count/index
TIMEOUT_W, 16, width of watchdog counter and limit
(derived) N_NODES = MESH_X*MESH_Y; node i = y*MESH_X + x

Ports:
clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous active-high reset
start  in  1  run request pulse, accepted only in IDLE
num_layers  in  LAYER_W  layers to run, sampled on accepted start
node_mask  in  N_NODES  1 = node participates in barrier, sampled on accepted start
timeout_limit  in  TIMEOUT_W  max RUN cycles per layer, 0 = watchdog off, sampled on accepted start
node_done  in  N_NODES  level done from each PE
layer_start  out  1  one-cycle pulse to all PEs at the beginning of each layer
layer_idx  out  LAYER_W  index of the current layer, 0-based
busy  out  1  high from LAUNCH through FINISH
layer_done  out  1  one-cycle pulse when a layer barrier completes
done_out  out  1  level, set at FINISH, cleared by the next accepted start or srst
timeout_err  out  1  sticky, set on watchdog expiry, cleared by accepted start or srst

Behaviour:
- All outputs are registered. Reset values: layer_start=0, layer_idx=0, busy=0, layer_done=0, done_out=0, timeout_err=0. State=IDLE. done_seen=0. node_done_q=0.
- States: IDLE, LAUNCH, RUN, FINISH, ERROR.
- IDLE:
  - start=1 captures num_layers_q, mask_q, limit_q, and clears done_out and timeout_err.
  - If num_layers==0, go to FINISH; otherwise go to LAUNCH.
  - start in any other state is ignored.
- LAUNCH (1 cycle): layer_start=1, done_seen cleared, watchdog cleared, then go to RUN.
- RUN:
  - Each cycle, done_seen |= node_done & ~node_done_q (rising edges only). node_done_q is registered every cycle in all states.
  - A done held high from the previous layer does not count; the PE must drop done and raise it again.
  - Barrier complete when &(done_seen | ~mask_q)==1, evaluated on registered done_seen. A rise arriving in cycle t therefore completes the barrier in cycle t+1.
  - On completion, layer_done pulses for 1 cycle.
    - If layer_idx==num_layers_q-1, go to FINISH.
    - Otherwise, increment layer_idx and go to LAUNCH.
  - Latency from the last required rising edge to the next layer_start: 2 cycles.
  - Watchdog: counter increments each RUN cycle. If limit_q!=0 and counter==limit_q-1 without completion, go to ERROR. Completion in the same cycle takes priority over timeout.
  - mask_q all zero: barrier completes on the first RUN cycle.
- FINISH (1 cycle): done_out<=1, layer_idx<=0, go to IDLE.
- ERROR:
  - timeout_err<=1, busy stays high, layer_idx is held for debug.
  - Exit only via srst. start is ignored.
- busy=1 in LAUNCH, RUN, FINISH and ERROR.
- srst mid-operation returns to the reset values in the next cycle. No layer_done or done_out pulse is generated.
- layer_idx does not wrap: num_layers max is 2^LAYER_W-1.
- Widths: watchdog counter is TIMEOUT_W bits and saturates (never wraps).

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs last_layer_cycles[TIMEOUT_W-1:0] and total_cycles[31:0].
  - last_layer_cycles is loaded with the RUN cycle count (LAUNCH excluded) on each layer_done.
  - total_cycles counts every busy cycle of the current run and saturates at all ones.
  - Both are cleared on accepted start and on srst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- MESH 2x2, mask=4'b1111, num_layers=3, limit=0; each PE pulses done 5 cycles after each layer_start -> 3 layer_start pulses, layer_done at layer_idx 0,1,2, done_out=1 after third, busy=0 after FINISH.
- mask=4'b1011, node 2 never asserts done, others pulse -> barrier completes; node 2 ignored.
- num_layers=2, node 0 done held high across the layer boundary -> layer 1 does not complete until node 0 drops and re-rises.
- limit=10, node 3 stuck low -> ERROR after 10 RUN cycles, timeout_err=1, layer_done never pulses; srst clears timeout_err.
- num_layers=0 -> done_out=1 two cycles after start, no layer_start; start during RUN ignored (layer_idx unchanged); srst during RUN -> all outputs 0 next cycle.
- PERF_CNT_EN build: done rises 7 cycles into RUN -> last_layer_cycles=8.

Source files
------------

// File: rtl/mesh_layer_barrier_if.sv
// -----------------------------------------------------------------------------
// mesh_layer_barrier_if
//
// Bundles the control, barrier and status signals of mesh_layer_barrier.
//   master : the side that issues runs and hosts the PEs (start, num_layers,
//            node_mask, timeout_limit, node_done are outputs)
//   slave  : the sequencer itself (layer_start, layer_idx, busy, layer_done,
//            done_out, timeout_err are outputs)
//
// Optional macro PERF_CNT_EN adds last_layer_cycles and total_cycles.
// -----------------------------------------------------------------------------
interface mesh_layer_barrier_if #(
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  parameter int LAYER_W   = 8,
  parameter int TIMEOUT_W = 16
);
  localparam int N_NODES = MESH_X * MESH_Y;

  // Run control, sampled by the sequencer on an accepted start
  logic                 start;
  logic [LAYER_W-1:0]   num_layers;
  logic [N_NODES-1:0]   node_mask;
  logic [TIMEOUT_W-1:0] timeout_limit;

  // Per-PE level done, node i = y*MESH_X + x
  logic [N_NODES-1:0]   node_done;

  // Sequencer status
  logic                 layer_start;
  logic [LAYER_W-1:0]   layer_idx;
  logic                 busy;
  logic                 layer_done;
  logic                 done_out;
  logic                 timeout_err;

`ifdef PERF_CNT_EN
  logic [TIMEOUT_W-1:0] last_layer_cycles;
  logic [31:0]          total_cycles;

  modport master (
    output start, num_layers, node_mask, timeout_limit, node_done,
    input  layer_start, layer_idx, busy, layer_done, done_out, timeout_err,
    input  last_layer_cycles, total_cycles
  );

  modport slave (
    input  start, num_layers, node_mask, timeout_limit, node_done,
    output layer_start, layer_idx, busy, layer_done, done_out, timeout_err,
    output last_layer_cycles, total_cycles
  );
`else
  modport master (
    output start, num_layers, node_mask, timeout_limit, node_done,
    input  layer_start, layer_idx, busy, layer_done, done_out, timeout_err
  );

  modport slave (
    input  start, num_layers, node_mask, timeout_limit, node_done,
    output layer_start, layer_idx, busy, layer_done, done_out, timeout_err
  );
`endif

endinterface

// File: rtl/mesh_layer_barrier.sv
// -----------------------------------------------------------------------------
// mesh_layer_barrier
//
// Mesh-level layer sequencer for a MESH_X x MESH_Y NoC of PEs. For each layer
// it broadcasts a one-cycle layer_start, collects rising edges of node_done
// into a masked barrier, and moves on to the next layer once every
// participating node has reported. A per-layer watchdog traps a stuck layer
// in ERROR until srst.
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   srst  : synchronous active-high reset
//   bus   : mesh_layer_barrier_if.slave
//           in : start, num_layers, node_mask, timeout_limit, node_done
//           out: layer_start, layer_idx, busy, layer_done, done_out,
//                timeout_err (all registered)
//
// Optional macro PERF_CNT_EN: adds last_layer_cycles (RUN cycles of the most
// recently completed layer) and total_cycles (saturating busy-cycle count of
// the current run). Both clear on accepted start and on srst.
// -----------------------------------------------------------------------------
module mesh_layer_barrier #(
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  parameter int LAYER_W   = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  mesh_layer_barrier_if.slave  bus
);

  localparam int N_NODES = MESH_X * MESH_Y;

  localparam logic [LAYER_W-1:0]   LAYER_ONE = LAYER_W'(1);
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_FINISH,
    S_ERROR
  } state_e;

  state_e               state_q;

  // Run configuration captured on an accepted start
  logic [LAYER_W-1:0]   num_layers_q;
  logic [N_NODES-1:0]   mask_q;
  logic [TIMEOUT_W-1:0] limit_q;

  // Barrier bookkeeping
  logic [N_NODES-1:0]   node_done_q;   // previous-cycle node_done, for edge detect
  logic [N_NODES-1:0]   done_seen_q;   // nodes that have risen during this layer
  logic [TIMEOUT_W-1:0] wdog_q;        // RUN cycles spent in the current layer

  // Registered outputs
  logic                 layer_start_q;
  logic [LAYER_W-1:0]   layer_idx_q;
  logic                 busy_q;
  logic                 layer_done_q;
  logic                 done_out_q;
  logic                 timeout_err_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [N_NODES-1:0]   done_rise;
  logic                 barrier_ok;
  logic                 last_layer;
  logic                 wdog_expire;
  logic [TIMEOUT_W-1:0] wdog_d;

  // Only a fresh rising edge counts, so a done left high from the previous
  // layer has to drop and rise again before it is credited.
  assign done_rise   = bus.node_done & ~node_done_q;

  // Evaluated on the registered seen-set: a rise in cycle t completes in t+1.
  // Masked-off nodes always read as done, so an all-zero mask completes on the
  // first RUN cycle.
  assign barrier_ok  = &(done_seen_q | ~mask_q);

  assign last_layer  = (layer_idx_q == (num_layers_q - LAYER_ONE));

  assign wdog_expire = (limit_q != '0) && (wdog_q == (limit_q - WDOG_ONE));

  // Saturating increment so a very long layer with the watchdog off never
  // wraps back to a small value.
  assign wdog_d      = (&wdog_q) ? wdog_q : (wdog_q + WDOG_ONE);

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= S_IDLE;
      num_layers_q  <= '0;
      mask_q        <= '0;
      limit_q       <= '0;
      node_done_q   <= '0;
      done_seen_q   <= '0;
      wdog_q        <= '0;
      layer_start_q <= 1'b0;
      layer_idx_q   <= '0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      done_out_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      node_done_q   <= bus.node_done;

      // NOTE: pulse outputs default low every cycle and are raised only on the
      // transition that owns them, which keeps them exactly one cycle wide.
      layer_start_q <= 1'b0;
      layer_done_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            num_layers_q  <= bus.num_layers;
            mask_q        <= bus.node_mask;
            limit_q       <= bus.timeout_limit;
            done_out_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            if (bus.num_layers == '0) begin
              state_q <= S_FINISH;
            end else begin
              state_q       <= S_LAUNCH;
              layer_start_q <= 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          done_seen_q <= '0;
          wdog_q      <= '0;
          state_q     <= S_RUN;
        end

        S_RUN: begin
          done_seen_q <= done_seen_q | done_rise;
          wdog_q      <= wdog_d;
          // Completion wins over a watchdog expiry in the same cycle.
          if (barrier_ok) begin
            layer_done_q <= 1'b1;
            if (last_layer) begin
              state_q <= S_FINISH;
            end else begin
              layer_idx_q   <= layer_idx_q + LAYER_ONE;
              layer_start_q <= 1'b1;
              state_q       <= S_LAUNCH;
            end
          end else if (wdog_expire) begin
            state_q <= S_ERROR;
          end
        end

        S_FINISH: begin
          done_out_q  <= 1'b1;
          layer_idx_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end

        S_ERROR: begin
          // Parked with busy high and layer_idx frozen until srst.
          timeout_err_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.layer_start = layer_start_q;
  assign bus.layer_idx   = layer_idx_q;
  assign bus.busy        = busy_q;
  assign bus.layer_done  = layer_done_q;
  assign bus.done_out    = done_out_q;
  assign bus.timeout_err = timeout_err_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  logic [TIMEOUT_W-1:0] last_layer_cycles_q;
  logic [31:0]          total_cycles_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      last_layer_cycles_q <= '0;
      total_cycles_q      <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      last_layer_cycles_q <= '0;
      total_cycles_q      <= '0;
    end else begin
      // wdog_d is the RUN-cycle count including the completing cycle.
      if ((state_q == S_RUN) && barrier_ok) begin
        last_layer_cycles_q <= wdog_d;
      end
      if (busy_q && (total_cycles_q != '1)) begin
        total_cycles_q <= total_cycles_q + 32'd1;
      end
    end
  end

  assign bus.last_layer_cycles = last_layer_cycles_q;
  assign bus.total_cycles      = total_cycles_q;
`endif

  // ---------------------------------------------------------------------------
  // Structural invariants of the sequencer
  // ---------------------------------------------------------------------------
  a_layer_start_one_cycle : assert property (@(posedge clk) disable iff (srst)
    layer_start_q |=> !layer_start_q);

  a_layer_start_busy : assert property (@(posedge clk) disable iff (srst)
    layer_start_q |-> busy_q);

  a_layer_done_busy : assert property (@(posedge clk) disable iff (srst)
    layer_done_q |-> busy_q);

  a_done_not_busy : assert property (@(posedge clk) disable iff (srst)
    done_out_q |-> !busy_q);

  a_err_parked : assert property (@(posedge clk) disable iff (srst)
    timeout_err_q |-> (state_q == S_ERROR));

endmodule

// File: tb/tb_mesh_layer_barrier.sv
// -----------------------------------------------------------------------------
// tb_mesh_layer_barrier
//
// Bench for mesh_layer_barrier on a 2x2 mesh. A behavioural model advances on
// each rising edge from the sequencing rules (phase, layer number, per-node
// seen flags, RUN-cycle count) and one compare process checks every output on
// each falling edge. Directed scenarios add hand-computed literal checks;
// a randomized section then mixes PE behaviours, masks, limits, stray starts
// and mid-run resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mesh_layer_barrier;

  localparam int MESH_X    = 2;
  localparam int MESH_Y    = 2;
  localparam int LAYER_W   = 8;
  localparam int TIMEOUT_W = 16;
  localparam int N         = MESH_X * MESH_Y;
  localparam longint TMAX  = (longint'(1) << TIMEOUT_W) - 1;

  // Model phases
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_FINISH = 3, P_ERROR = 4;

  // PE behaviours
  localparam int PE_PULSE = 0, PE_STICKY = 1, PE_LOW = 2, PE_HIGH = 3, PE_RAND = 4;

  logic clk  = 1'b0;
  logic srst = 1'b1;

  mesh_layer_barrier_if #(
    .MESH_X(MESH_X), .MESH_Y(MESH_Y), .LAYER_W(LAYER_W), .TIMEOUT_W(TIMEOUT_W)
  ) bus ();

  mesh_layer_barrier #(
    .MESH_X(MESH_X), .MESH_Y(MESH_Y), .LAYER_W(LAYER_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          m_phase = P_IDLE;
  int          m_layer = 0;
  int          m_n     = 0;
  int          m_limit = 0;
  int          m_runc  = 0;
  bit [N-1:0]  m_mask  = '0;
  bit [N-1:0]  m_seen  = '0;
  bit [N-1:0]  m_prev  = '0;
  bit          m_ld    = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_terr  = 1'b0;
  longint      m_last  = 0;
  longint      m_total = 0;

  always @(posedge clk) begin : model
    int missing;
    int ph;
    ph   = m_phase;
    m_ld = 1'b0;
    if (srst) begin
      m_phase = P_IDLE; m_layer = 0; m_n = 0; m_limit = 0; m_runc = 0;
      m_mask = '0; m_seen = '0; m_done = 1'b0; m_terr = 1'b0;
      m_last = 0; m_total = 0;
      m_prev = '0;
    end else begin
      if (ph != P_IDLE && m_total < 64'hFFFF_FFFF) m_total++;
      case (ph)
        P_IDLE: if (bus.start) begin
          m_n     = int'(bus.num_layers);
          m_mask  = bus.node_mask;
          m_limit = int'(bus.timeout_limit);
          m_done  = 1'b0;
          m_terr  = 1'b0;
          m_last  = 0;
          m_total = 0;
          m_phase = (m_n == 0) ? P_FINISH : P_LAUNCH;
        end
        P_LAUNCH: begin
          m_seen  = '0;
          m_runc  = 0;
          m_phase = P_RUN;
        end
        P_RUN: begin
          missing = 0;
          for (int i = 0; i < N; i++) if (m_mask[i] && !m_seen[i]) missing++;
          for (int i = 0; i < N; i++) if (bus.node_done[i] && !m_prev[i]) m_seen[i] = 1'b1;
          if (missing == 0) begin
            m_ld   = 1'b1;
            m_last = (m_runc + 1 > TMAX) ? TMAX : longint'(m_runc + 1);
            if (m_layer == m_n - 1) m_phase = P_FINISH;
            else begin
              m_layer++;
              m_phase = P_LAUNCH;
            end
          end else if (m_limit != 0 && m_runc == m_limit - 1) begin
            m_phase = P_ERROR;
          end
          if (m_runc < TMAX) m_runc++;
        end
        P_FINISH: begin
          m_done  = 1'b1;
          m_layer = 0;
          m_phase = P_IDLE;
        end
        P_ERROR: m_terr = 1'b1;
        default: m_phase = P_IDLE;
      endcase
      m_prev = bus.node_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, away from the rising edge
  // ---------------------------------------------------------------------------
  bit cmp_en     = 1'b0;
  int dut_ls_cnt = 0;
  int dut_ld_cnt = 0;
  int m_ls_cnt   = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_layer_start", 32'(bus.layer_start), 32'(m_phase == P_LAUNCH));
      check("cyc_layer_idx",   32'(bus.layer_idx),   32'(m_layer));
      check("cyc_busy",        32'(bus.busy),        32'(m_phase != P_IDLE));
      check("cyc_layer_done",  32'(bus.layer_done),  32'(m_ld));
      check("cyc_done_out",    32'(bus.done_out),    32'(m_done));
      check("cyc_timeout_err", 32'(bus.timeout_err), 32'(m_terr));
`ifdef PERF_CNT_EN
      check("cyc_last_layer_cycles", 32'(bus.last_layer_cycles), 32'(m_last));
      check("cyc_total_cycles",      bus.total_cycles,           32'(m_total));
`endif
      if (bus.layer_start === 1'b1) dut_ls_cnt++;
      if (bus.layer_done === 1'b1)  dut_ld_cnt++;
      if (m_phase == P_LAUNCH)      m_ls_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: PE emulation runs once per cycle, just after the edge
  // ---------------------------------------------------------------------------
  int pe_mode  [N];
  int pe_delay [N];
  int pe_cnt   [N];

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      case (pe_mode[i])
        PE_PULSE, PE_STICKY: begin
          if (pe_mode[i] == PE_PULSE) bus.node_done[i] = 1'b0;
          if (bus.layer_start === 1'b1) pe_cnt[i] = pe_delay[i];
          else if (pe_cnt[i] > 0) begin
            pe_cnt[i]--;
            if (pe_cnt[i] == 0) bus.node_done[i] = 1'b1;
          end
        end
        PE_LOW:  bus.node_done[i] = 1'b0;
        PE_HIGH: bus.node_done[i] = 1'b1;
        default: bus.node_done[i] = ($urandom_range(0, 3) == 0);
      endcase
    end
  endtask

  task automatic drive_start(input int n, input logic [N-1:0] mask, input int lim);
    bus.num_layers    = LAYER_W'(n);
    bus.node_mask     = mask;
    bus.timeout_limit = TIMEOUT_W'(lim);
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
  endtask

  task automatic set_all(input int mode, input int dly);
    for (int i = 0; i < N; i++) begin
      pe_mode[i]  = mode;
      pe_delay[i] = dly;
      pe_cnt[i]   = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int ls_cyc[$];
  int ld0, mls0, ls0, k;

  initial begin
    bus.start = 1'b0; bus.num_layers = '0; bus.node_mask = '0;
    bus.timeout_limit = '0; bus.node_done = '0;
    set_all(PE_LOW, 1);

    // Reset state
    srst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_busy",        32'(bus.busy),        0);
    check("rst_layer_idx",   32'(bus.layer_idx),   0);
    check("rst_done_out",    32'(bus.done_out),    0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    srst = 1'b0;
    tick();

    // Three layers, every PE pulses 5 cycles after each layer_start
    set_all(PE_PULSE, 5);
    ld0 = dut_ld_cnt; mls0 = m_ls_cnt;
    ls_cyc.delete();
    drive_start(3, 4'b1111, 0);
    if (bus.layer_start === 1'b1) ls_cyc.push_back(0);
    for (k = 1; k < 200 && bus.done_out !== 1'b1; k++) begin
      tick();
      if (bus.layer_start === 1'b1) ls_cyc.push_back(k);
    end
    check("s1_done_out", 32'(bus.done_out), 1);
    tick();
    check("s1_busy_after_finish", 32'(bus.busy), 0);
    check("s1_layer_starts", 32'(ls_cyc.size()), 3);
    check("s1_layer_dones", 32'(dut_ld_cnt - ld0), 3);
    check("s1_model_layer_starts", 32'(m_ls_cnt - mls0), 3);
    if (ls_cyc.size() >= 2) check("s1_layer_period", 32'(ls_cyc[1] - ls_cyc[0]), 7);

    // Masked-out node 2 never reports
    set_all(PE_PULSE, 3);
    pe_mode[2] = PE_LOW;
    drive_start(1, 4'b1011, 0);
    for (k = 0; k < 50 && bus.done_out !== 1'b1; k++) tick();
    check("s2_masked_done_out", 32'(bus.done_out), 1);
    tick();

    // Node 0 holds done high across the layer boundary
    set_all(PE_PULSE, 2);
    pe_mode[0] = PE_STICKY;
    ld0 = dut_ld_cnt;
    drive_start(2, 4'b1111, 0);
    repeat (20) tick();
    check("s3_held_layer_idx", 32'(bus.layer_idx), 1);
    check("s3_held_layer_dones", 32'(dut_ld_cnt - ld0), 1);
    check("s3_held_done_out", 32'(bus.done_out), 0);
    pe_mode[0] = PE_LOW;
    tick();
    pe_mode[0] = PE_HIGH;
    for (k = 0; k < 30 && bus.done_out !== 1'b1; k++) tick();
    check("s3_rerise_done_out", 32'(bus.done_out), 1);
    check("s3_rerise_layer_dones", 32'(dut_ld_cnt - ld0), 2);
    tick();

    // Watchdog: limit 10, node 3 stuck low
    set_all(PE_PULSE, 2);
    pe_mode[3] = PE_LOW;
    ld0 = dut_ld_cnt;
    drive_start(1, 4'b1111, 10);
    for (k = 0; k < 40 && bus.timeout_err !== 1'b1; k++) tick();
    check("s4_timeout_latency", 32'(k), 12);
    check("s4_no_layer_done", 32'(dut_ld_cnt - ld0), 0);
    bus.num_layers = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("s4_error_busy", 32'(bus.busy), 1);
    check("s4_error_sticky", 32'(bus.timeout_err), 1);
    srst = 1'b1;
    tick();
    check("s4_srst_clears_err", 32'(bus.timeout_err), 0);
    srst = 1'b0;
    tick();

    // Zero layers: done_out two cycles after start, no layer_start
    ls0 = dut_ls_cnt;
    drive_start(0, 4'b1111, 0);
    tick();
    check("s5_zero_layers_done", 32'(bus.done_out), 1);
    check("s5_zero_layers_no_start", 32'(dut_ls_cnt - ls0), 0);
    tick();

    // All-zero mask: each layer completes on its first RUN cycle
    drive_start(2, 4'b0000, 0);
    repeat (5) tick();
    check("s6_empty_mask_done", 32'(bus.done_out), 1);
    tick();

    // start during RUN is ignored; srst during RUN clears everything
    set_all(PE_PULSE, 2);
    drive_start(3, 4'b1111, 0);
    repeat (5) tick();
    set_all(PE_LOW, 1);
    bus.num_layers = 8'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("s7_start_ignored_idx", 32'(bus.layer_idx), 1);
    check("s7_start_ignored_busy", 32'(bus.busy), 1);
    srst = 1'b1;
    tick();
    check("s7_srst_layer_start", 32'(bus.layer_start), 0);
    check("s7_srst_layer_idx",   32'(bus.layer_idx),   0);
    check("s7_srst_busy",        32'(bus.busy),        0);
    check("s7_srst_layer_done",  32'(bus.layer_done),  0);
    check("s7_srst_done_out",    32'(bus.done_out),    0);
    check("s7_srst_timeout_err", 32'(bus.timeout_err), 0);
    srst = 1'b0;
    tick();

`ifdef PERF_CNT_EN
    // Done rises 7 cycles after layer_start: 8 RUN cycles, 10 busy cycles
    set_all(PE_PULSE, 7);
    drive_start(1, 4'b1111, 0);
    for (k = 0; k < 40 && bus.done_out !== 1'b1; k++) tick();
    check("perf_last_layer_cycles", 32'(bus.last_layer_cycles), 8);
    check("perf_total_cycles", bus.total_cycles, 10);
    tick();
`endif

    // Randomized runs against the model
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 4))
          0, 1: begin pe_mode[i] = PE_PULSE; pe_delay[i] = $urandom_range(1, 9); end
          2:    begin pe_mode[i] = PE_STICKY; pe_delay[i] = $urandom_range(1, 6); end
          3:    pe_mode[i] = PE_RAND;
          default: pe_mode[i] = (r % 3 == 0) ? PE_LOW : PE_RAND;
        endcase
      end
      drive_start($urandom_range(1, 4), N'($urandom),
                  ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 30));
      for (int c = 0; c < 200; c++) begin
        bus.start = ($urandom_range(0, 15) == 0);
        if (bus.start) bus.num_layers = LAYER_W'($urandom_range(0, 3));
        srst = ($urandom_range(0, 199) == 0);
        tick();
        if (bus.busy === 1'b0 && bus.done_out === 1'b1) break;
      end
      bus.start = 1'b0;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      tick();
    end

    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
